// File: rtl/hc32_share_arb.sv
// hc32_share_arb: round-robin arbiter that time-shares one hc32 quad OR gate
// among NREQ requesters. A granted requester's operands are driven onto the
// gate, held for SETTLE cycles, then the gate output is captured as result.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req[NREQ]         per-requester request
//   op_a/op_b         packed operands, requester i at [i*W +: W]
//   gnt[NREQ]         one-hot owner of the gate, grant through SAMPLE
//   done[NREQ]        one-hot single-cycle completion pulse
//   result[W]         captured gate output of the last completed transaction
//   busy              FSM not idle
//   gate_a/gate_b     registered drive to the shared gate inputs
//   gate_y            shared gate output
module hc32_share_arb #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned W      = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              busy,
    output logic [W-1:0]      gate_a,
    output logic [W-1:0]      gate_b,
    input  logic [W-1:0]      gate_y
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [W-1:0]      result_q, result_d;
    logic              busy_q, busy_d;
    logic [W-1:0]      gate_a_q, gate_a_d;
    logic [W-1:0]      gate_b_q, gate_b_d;

    logic              found_c;
    logic [PW-1:0]     win_c;
    int unsigned       idx_c;

    // Cyclic first-set search starting at ptr.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            idx_c = int'(ptr_q) + off;
            if (idx_c >= NREQ) begin
                idx_c = idx_c - NREQ;
            end
            if (!found_c && req[PW'(idx_c)]) begin
                found_c = 1'b1;
                win_c   = PW'(idx_c);
            end
        end
    end

    // Next-state and output computation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        result_d = result_q;
        gate_a_d = gate_a_q;
        gate_b_d = gate_b_q;

        case (state_q)
            IDLE: begin
                if (found_c) begin
                    gnt_d    = NREQ'(1) << win_c;
                    gate_a_d = op_a[int'(win_c)*W +: W];
                    gate_b_d = op_b[int'(win_c)*W +: W];
                    cnt_d    = '0;
                    ptr_d    = (win_c == PW'(NREQ-1)) ? '0 : win_c + PW'(1);
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SETTLE-1)) begin
                    result_d = gate_y;
                    done_d   = gnt_q;
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                gnt_d   = '0;
                done_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State register; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            gate_a_q <= '0;
            gate_b_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            gate_a_q <= gate_a_d;
            gate_b_q <= gate_b_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign gate_a = gate_a_q;
    assign gate_b = gate_b_q;

endmodule

// File: tb/tb_hc32_share_arb.sv
// Directed testbench for hc32_share_arb: one instance with SETTLE=1, one
// with SETTLE=3, each driving an hc32 OR-gate model.
module tb_hc32_share_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [3:0]  req1 = '0;
    logic [15:0] op_a1 = '0, op_b1 = '0;
    logic [3:0]  gnt1, done1, result1, ga1, gb1, gy1;
    logic        busy1;

    logic [3:0]  req3 = '0;
    logic [15:0] op_a3 = '0, op_b3 = '0;
    logic [3:0]  gnt3, done3, result3, ga3, gb3, gy3;
    logic        busy3;
    logic        corrupt3 = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // hc32 quad 2-input OR gate models; dut3's can be forced wrong while settling
    assign gy1 = ga1 | gb1;
    assign gy3 = corrupt3 ? ~(ga3 | gb3) : (ga3 | gb3);

    hc32_share_arb #(.NREQ(4), .W(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .op_a(op_a1), .op_b(op_b1),
        .gnt(gnt1), .done(done1), .result(result1), .busy(busy1),
        .gate_a(ga1), .gate_b(gb1), .gate_y(gy1)
    );

    hc32_share_arb #(.NREQ(4), .W(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .op_a(op_a3), .op_b(op_b3),
        .gnt(gnt3), .done(done3), .result(result3), .busy(busy3),
        .gate_a(ga3), .gate_b(gb3), .gate_y(gy3)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if ({gnt1, done1, result1, ga1, gb1, busy1} !== 21'd0) begin errors++; $display("FAIL reset dut1: got %h want 0", {gnt1, done1, result1, ga1, gb1, busy1}); end
        checks++; if ({gnt3, done3, result3, ga3, gb3, busy3} !== 21'd0) begin errors++; $display("FAIL reset dut3: got %h want 0", {gnt3, done3, result3, ga3, gb3, busy3}); end
    endtask

    task automatic test_single();
        req1 = 4'b0100;
        op_a1 = 16'h0A00;
        op_b1 = 16'h0500;
        tick(1);
        req1 = 4'b0000;
        checks++; if (gnt1 !== 4'b0100) begin errors++; $display("FAIL single gnt: got %b want 0100", gnt1); end
        checks++; if (busy1 !== 1'b1 || done1 !== 4'b0000) begin errors++; $display("FAIL single drive busy/done: got %b/%b want 1/0000", busy1, done1); end
        checks++; if (ga1 !== 4'hA || gb1 !== 4'h5) begin errors++; $display("FAIL single gate: got %h/%h want a/5", ga1, gb1); end
        tick(1);
        checks++; if (done1 !== 4'b0100 || result1 !== 4'hF) begin errors++; $display("FAIL single done/result: got %b/%h want 0100/f", done1, result1); end
        checks++; if (gnt1 !== 4'b0100) begin errors++; $display("FAIL single sample gnt: got %b want 0100", gnt1); end
        tick(1);
        checks++; if (busy1 !== 1'b0 || done1 !== 4'b0000 || gnt1 !== 4'b0000) begin errors++; $display("FAIL single idle: got busy=%b done=%b gnt=%b want 0/0000/0000", busy1, done1, gnt1); end
        checks++; if (result1 !== 4'hF || ga1 !== 4'hA) begin errors++; $display("FAIL single hold: got result=%h ga=%h want f/a", result1, ga1); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [3:0] exp_r [5] = '{4'h3, 4'h2, 4'h5, 4'h8, 4'h3};
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        // lanes 3..0: a = 8,4,2,1  b = 0,1,0,2
        op_a1 = 16'h8421;
        op_b1 = 16'h0102;
        req1  = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            checks++; if (gnt1 !== exp_g[t]) begin errors++; $display("FAIL rr gnt %0d: got %b want %b", t, gnt1, exp_g[t]); end
            tick(1);
            checks++; if (done1 !== exp_g[t] || result1 !== exp_r[t]) begin errors++; $display("FAIL rr done %0d: got %b/%h want %b/%h", t, done1, result1, exp_g[t], exp_r[t]); end
            tick(1);
            checks++; if (done1 !== 4'b0000 || busy1 !== 1'b0) begin errors++; $display("FAIL rr gap %0d: got done=%b busy=%b want 0000/0", t, done1, busy1); end
        end
        req1 = 4'b0000;
    endtask

    task automatic test_truth_table();
        logic [3:0] exp;
        req1 = 4'b0010;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op_a1 = {4'h0, 4'h0, 4'(a), 4'h0};
                op_b1 = {4'h0, 4'h0, 4'(b), 4'h0};
                exp = 4'(a) | 4'(b);
                tick(2);
                checks++; if (done1 !== 4'b0010 || result1 !== exp) begin errors++; $display("FAIL truth a=%h b=%h: got %b/%h want 0010/%h", a, b, done1, result1, exp); end
                tick(1);
            end
        end
        req1 = 4'b0000;
        tick(1);
    endtask

    task automatic test_reset_mid_drive();
        req1 = 4'b0100;
        op_a1 = 16'h0300;
        op_b1 = 16'h0400;
        tick(1);
        checks++; if (busy1 !== 1'b1 || gnt1 !== 4'b0100) begin errors++; $display("FAIL rstmid pre: got busy=%b gnt=%b want 1/0100", busy1, gnt1); end
        req1 = 4'b0000;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if ({gnt1, done1, result1, ga1, gb1, busy1} !== 21'd0) begin errors++; $display("FAIL rstmid clear: got %h want 0", {gnt1, done1, result1, ga1, gb1, busy1}); end
        tick(2);
        checks++; if (done1 !== 4'b0000 || result1 !== 4'h0) begin errors++; $display("FAIL rstmid no done: got %b/%h want 0000/0", done1, result1); end
        // ptr restarts at 0: requester 1 wins over 3
        req1 = 4'b1010;
        tick(1);
        req1 = 4'b0000;
        checks++; if (gnt1 !== 4'b0010) begin errors++; $display("FAIL rstmid regrant: got %b want 0010", gnt1); end
        tick(2);
    endtask

    task automatic test_churn();
        req1 = 4'b0100;
        op_a1 = 16'h0900;
        op_b1 = 16'h0200;
        tick(1);
        checks++; if (gnt1 !== 4'b0100 || ga1 !== 4'h9) begin errors++; $display("FAIL churn grant: got %b/%h want 0100/9", gnt1, ga1); end
        op_a1 = 16'h0600;
        op_b1 = 16'hFFFF;
        req1  = 4'b0000;
        tick(1);
        checks++; if (ga1 !== 4'h9 || gb1 !== 4'h2) begin errors++; $display("FAIL churn gate: got %h/%h want 9/2", ga1, gb1); end
        checks++; if (done1 !== 4'b0100 || result1 !== 4'hB) begin errors++; $display("FAIL churn done: got %b/%h want 0100/b", done1, result1); end
        tick(1);
        checks++; if (done1 !== 4'b0000 || busy1 !== 1'b0) begin errors++; $display("FAIL churn end: got %b/%b want 0000/0", done1, busy1); end
    endtask

    task automatic test_wrap();
        // ptr is now 3: expect 3, 0, 3 with the wrap through NREQ-1
        logic [3:0] exp_g [3] = '{4'b1000, 4'b0001, 4'b1000};
        req1 = 4'b1001;
        for (int t = 0; t < 3; t++) begin
            tick(1);
            checks++; if (gnt1 !== exp_g[t]) begin errors++; $display("FAIL wrap gnt %0d: got %b want %b", t, gnt1, exp_g[t]); end
            tick(2);
        end
        req1 = 4'b0000;
        tick(1);
    endtask

    task automatic test_settle3();
        req3 = 4'b0010;
        op_a3 = 16'h0050;
        op_b3 = 16'h0020;
        corrupt3 = 1'b1;
        tick(1);
        req3 = 4'b0000;
        checks++; if (gnt3 !== 4'b0010 || busy3 !== 1'b1) begin errors++; $display("FAIL s3 grant: got %b/%b want 0010/1", gnt3, busy3); end
        tick(1);
        checks++; if (done3 !== 4'b0000) begin errors++; $display("FAIL s3 early1: got %b want 0000", done3); end
        tick(1);
        checks++; if (done3 !== 4'b0000) begin errors++; $display("FAIL s3 early2: got %b want 0000", done3); end
        corrupt3 = 1'b0;
        tick(1);
        checks++; if (done3 !== 4'b0010 || result3 !== 4'h7) begin errors++; $display("FAIL s3 done: got %b/%h want 0010/7", done3, result3); end
        checks++; if (ga3 !== 4'h5 || gb3 !== 4'h2) begin errors++; $display("FAIL s3 gate: got %h/%h want 5/2", ga3, gb3); end
        tick(1);
        checks++; if (done3 !== 4'b0000 || busy3 !== 1'b0 || gnt3 !== 4'b0000) begin errors++; $display("FAIL s3 end: got %b/%b/%b want 0000/0/0000", done3, busy3, gnt3); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single();
        test_round_robin();
        test_truth_table();
        test_reset_mid_drive();
        test_churn();
        test_wrap();
        test_settle3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hc32_share_arb.md
HC32_SHARE_ARB -- requirements
Module: hc32_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one hc32 quad OR gate; legal range 2..8.
REQ-002 Parameter W, default 4: gate width in bits, one bit per hc32 section.
REQ-003 Parameter SETTLE, default 1: cycles the gate inputs are held before the output is sampled; SETTLE >= 1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  NREQ  req[i] high = requester i wants one OR operation.
REQ-007 op_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
REQ-008 op_b  in  NREQ*W  operand B, same packing as op_a.
REQ-009 gnt  out  NREQ  one-hot; marks the requester owning the gate; high from grant through the SAMPLE cycle.
REQ-010 done  out  NREQ  one-hot, one-cycle pulse; marks completion for the granted requester.
REQ-011 result  out  W  registered A|B of the last completed transaction; valid while done is nonzero; held afterwards.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 gate_a  out  W  registered drive to the shared gate's A inputs.
REQ-014 gate_b  out  W  registered drive to the shared gate's B inputs.
REQ-015 gate_y  in  W  shared gate output; sampled only at the end of DRIVE.

Function
REQ-016 FSM states SHALL be IDLE, DRIVE and SAMPLE; no other reachable states.
REQ-017 IDLE with req == 0: remain in IDLE; all outputs hold.
REQ-018 IDLE with req != 0: the winner is the first i with req[i] = 1, searching cyclically from ptr.
REQ-019 At that same edge: gnt <= onehot(winner); gate_a/gate_b <= the winner's operands; cnt <= 0; ptr <= (winner+1) mod NREQ; next state DRIVE.
REQ-020 DRIVE: cnt increments each cycle; when cnt == SETTLE-1, at that edge result <= gate_y, done <= onehot(winner), next state SAMPLE.
REQ-021 SAMPLE lasts exactly one cycle; at its end gnt <= 0, done <= 0, next state IDLE; gate_a/gate_b keep their last values.
REQ-022 Latency: req sampled in IDLE at edge k -> done high in the cycle after edge k+SETTLE; one transaction per SETTLE+2 cycles at most.
REQ-023 Operands SHALL be captured only at grant; op_a/op_b changes after grant SHALL NOT affect gate_a, gate_b or result.
REQ-024 Deasserting req[winner] mid-transaction SHALL NOT abort it; done[winner] still pulses.
REQ-025 A requester holding req high after its done SHALL be re-granted only after every other active requester has been served once.
REQ-026 done and gnt SHALL never be asserted for more than one requester at a time; done SHALL never be asserted outside SAMPLE.
REQ-027 The ptr wrap from NREQ-1 to 0 SHALL be modular; no requester is skipped or served twice within one round.

Reset
REQ-028 rst high at any edge: state <= IDLE, ptr <= 0, cnt <= 0, gnt/done/result/gate_a/gate_b <= 0, busy = 0.
REQ-029 Reset mid-DRIVE or mid-SAMPLE SHALL discard the in-flight transaction: no done pulse follows, and result is 0.
REQ-030 rst has priority over every other transition; the first grant after reset follows the REQ-018 search with ptr = 0.

Verification
REQ-031 Single requester: NREQ=4, SETTLE=1, req=0100, op_a[2]=1010, op_b[2]=0101 -> gnt=0100 one cycle later; done=0100 and result=1111 the cycle after; busy low afterwards.
REQ-032 Round robin: req=1111 held -> done pulses in order 0001, 0010, 0100, 1000, 0001, each spaced 3 cycles apart.
REQ-033 Truth table: one requester sweeps all 16 (a,b) pairs per bit lane -> result == a|b every time, checked with hc32 as the gate model.
REQ-034 Reset mid-DRIVE: rst asserted during DRIVE -> next cycle all outputs 0 and no done pulse; a req afterwards is granted to the first active requester at or after 0.
REQ-035 Operand and req churn: op_a and req[winner] changed the cycle after grant -> gate_a unchanged and done[winner] still pulses with the originally captured result.
REQ-036 SETTLE=3: single request -> done exactly 4 cycles after the req-sampling edge; gate_y sampled once.
